// File: rtl/int_to_fp_pipe.sv
`default_nettype none
// ============================================================================
// int_to_fp_pipe : 3-stage integer-to-float converter, valid/ready both sides
// Rev 1.0
// ============================================================================
module int_to_fp_pipe #(
   parameter int INT_W = 32,
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [INT_W-1:0]         int_i,
   input  logic                     signed_i,
   input  logic [1:0]               rnd_mode_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [EXP_W+MAN_W:0]     fp_o,
   output logic                     inexact_o,
   output logic                     overflow_o
);

   localparam int c_FP_W  = 1 + EXP_W + MAN_W;
   localparam int c_PW    = (INT_W > 1) ? $clog2(INT_W) : 1;
   localparam int c_EW    = ((EXP_W > c_PW) ? EXP_W : c_PW) + 2;
   localparam int c_XW    = INT_W + MAN_W + 1;
   localparam logic [c_EW-1:0] c_BIAS    = c_EW'(2**(EXP_W-1) - 1);
   localparam logic [c_EW-1:0] c_EXP_TOP = c_EW'(2**EXP_W - 1);

   localparam logic [1:0] c_RNE = 2'b00;
   localparam logic [1:0] c_RTZ = 2'b01;
   localparam logic [1:0] c_RDN = 2'b10;
   localparam logic [1:0] c_RUP = 2'b11;

   // Stage registers
   logic                r_rdy;
   logic                r_s1_v;
   logic [INT_W-1:0]    r_s1_mag;
   logic                r_s1_sign;
   logic [1:0]          r_s1_rnd;

   logic                r_s2_v;
   logic                r_s2_zero;
   logic                r_s2_sign;
   logic [1:0]          r_s2_rnd;
   logic [c_EW-1:0]     r_s2_exp;
   logic [MAN_W-1:0]    r_s2_man;
   logic                r_s2_g;
   logic                r_s2_s;

   logic                r_s3_v;
   logic [c_FP_W-1:0]   r_s3_fp;
   logic                r_s3_inx;
   logic                r_s3_ovf;

   // Flow control: a stage may load when its own register is empty or draining
   logic w_s3_free;
   logic w_s2_free;
   logic w_s1_free;
   logic w_in_fire;

   assign w_s3_free  = !r_s3_v || out_ready_i;
   assign w_s2_free  = !r_s2_v || w_s3_free;
   assign w_s1_free  = !r_s1_v || w_s2_free;
   assign in_ready_o = r_rdy && w_s1_free;
   assign w_in_fire  = in_valid_i && in_ready_o;

   // ---------------- S1: sign and magnitude ----------------
   logic             w_neg;
   logic [INT_W-1:0] w_mag;

   assign w_neg = signed_i && int_i[INT_W-1];
   assign w_mag = w_neg ? (~int_i + INT_W'(1)) : int_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rdy     <= 1'b0;
         r_s1_v    <= 1'b0;
         r_s1_mag  <= '0;
         r_s1_sign <= 1'b0;
         r_s1_rnd  <= 2'b00;
      end else begin
         r_rdy <= 1'b1;
         if (in_ready_o) begin
            r_s1_v <= in_valid_i;
         end
         if (w_in_fire) begin
            r_s1_mag  <= w_mag;
            r_s1_sign <= w_neg;
            r_s1_rnd  <= rnd_mode_i;
         end
      end
   end

   // ---------------- S2: normalise ----------------
   logic [c_PW-1:0]  w_pos;
   logic [c_PW-1:0]  w_shamt;
   logic [INT_W-1:0] w_norm;
   logic [c_XW-1:0]  w_ext;

   always_comb begin
      w_pos = '0;
      for (int i = 0; i < INT_W; i++) begin
         if (r_s1_mag[i]) begin
            w_pos = c_PW'(i);
         end
      end
   end

   assign w_shamt = c_PW'(INT_W - 1) - w_pos;
   assign w_norm  = r_s1_mag << w_shamt;
   // Fraction bits below the hidden one, zero-padded so guard/sticky exist for any widths
   assign w_ext   = {w_norm[INT_W-2:0], {(MAN_W + 2){1'b0}}};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s2_v    <= 1'b0;
         r_s2_zero <= 1'b0;
         r_s2_sign <= 1'b0;
         r_s2_rnd  <= 2'b00;
         r_s2_exp  <= '0;
         r_s2_man  <= '0;
         r_s2_g    <= 1'b0;
         r_s2_s    <= 1'b0;
      end else begin
         if (w_s2_free) begin
            r_s2_v <= r_s1_v;
         end
         if (w_s2_free && r_s1_v) begin
            r_s2_zero <= !w_norm[INT_W-1];
            r_s2_sign <= r_s1_sign;
            r_s2_rnd  <= r_s1_rnd;
            r_s2_exp  <= c_EW'(w_pos) + c_BIAS;
            r_s2_man  <= w_ext[c_XW-1 -: MAN_W];
            r_s2_g    <= w_ext[c_XW-1-MAN_W];
            r_s2_s    <= |w_ext[c_XW-2-MAN_W:0];
         end
      end
   end

   // ---------------- S3: round, overflow, pack ----------------
   logic                w_inc;
   logic [MAN_W:0]      w_man_sum;
   logic [c_EW-1:0]     w_exp_r;
   logic                w_ovf;
   logic [c_FP_W-1:0]   w_inf;
   logic [c_FP_W-1:0]   w_maxf;
   logic [c_FP_W-1:0]   w_fp;
   logic                w_inx;

   always_comb begin
      w_inc = 1'b0;
      case (r_s2_rnd)
         c_RNE:   w_inc = r_s2_g && (r_s2_s || r_s2_man[0]);
         c_RTZ:   w_inc = 1'b0;
         c_RDN:   w_inc = r_s2_sign && (r_s2_g || r_s2_s);
         c_RUP:   w_inc = !r_s2_sign && (r_s2_g || r_s2_s);
         default: w_inc = 1'b0;
      endcase
   end

   assign w_man_sum = {1'b0, r_s2_man} + (MAN_W + 1)'(w_inc);
   assign w_exp_r   = r_s2_exp + c_EW'(w_man_sum[MAN_W]);
   assign w_ovf     = (w_exp_r >= c_EXP_TOP);
   assign w_inf     = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   assign w_maxf    = {r_s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

   always_comb begin
      w_fp  = '0;
      w_inx = 1'b0;
      if (r_s2_zero) begin
         w_fp  = '0;
         w_inx = 1'b0;
      end else if (w_ovf) begin
         w_inx = 1'b1;
         case (r_s2_rnd)
            c_RNE:   w_fp = w_inf;
            c_RTZ:   w_fp = w_maxf;
            c_RDN:   w_fp = r_s2_sign ? w_inf : w_maxf;
            c_RUP:   w_fp = r_s2_sign ? w_maxf : w_inf;
            default: w_fp = w_inf;
         endcase
      end else begin
         w_fp  = {r_s2_sign, w_exp_r[EXP_W-1:0], w_man_sum[MAN_W-1:0]};
         w_inx = r_s2_g || r_s2_s;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s3_v   <= 1'b0;
         r_s3_fp  <= '0;
         r_s3_inx <= 1'b0;
         r_s3_ovf <= 1'b0;
      end else begin
         if (w_s3_free) begin
            r_s3_v <= r_s2_v;
         end
         if (w_s3_free && r_s2_v) begin
            r_s3_fp  <= w_fp;
            r_s3_inx <= w_inx;
            r_s3_ovf <= w_ovf && !r_s2_zero;
         end
      end
   end

   assign out_valid_o = r_s3_v;
   assign fp_o        = r_s3_fp;
   assign inexact_o   = r_s3_inx;
   assign overflow_o  = r_s3_ovf;

endmodule
`default_nettype wire

// File: doc/int_to_fp_pipe.md
Name: int_to_fp_pipe

Overview:
- Parametrised, pipelined integer-to-floating-point converter for the FPU datapath.
- Converts signed or unsigned INT_W-bit integers to a 1+EXP_W+MAN_W float. Default format is bfloat16.
- Supports four IEEE rounding modes, raises inexact/overflow flags, and uses a valid/ready handshake on both sides.
- Sits between the integer register-read stage and the FPU writeback.

Parameters:
- INT_W, 32, integer input width (>=8).
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1 is derived, not a parameter.
- MAN_W, 7, stored mantissa width (hidden bit excluded).

Ports:
- clk_i, input, 1, clock, rising edge.
- rst_ni, input, 1, asynchronous active-low reset.
- in_valid_i, input, 1, input operand valid.
- in_ready_o, output, 1, converter can accept an operand this cycle.
- int_i, input, INT_W, integer operand.
- signed_i, input, 1, 1 = two's complement; 0 = unsigned.
- rnd_mode_i, input, 2, rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
- out_valid_o, output, 1, result valid.
- out_ready_i, input, 1, consumer accepts result.
- fp_o, output, 1+EXP_W+MAN_W, packed result {sign, exp, man}.
- inexact_o, output, 1, result differs from the exact value.
- overflow_o, output, 1, magnitude exceeds the largest finite value.

Behaviour:
- Reset: all stage valid bits cleared; out_valid_o=0, fp_o=0, inexact_o=0, overflow_o=0. in_ready_o=1 one cycle after reset deassertion. Reset asserted mid-operation discards all in-flight operands; no output is produced for them.
- Transfer rules:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - fp_o and the flags are held stable while out_valid_o && !out_ready_i.
- Pipeline: 3 register stages, so latency is 3 cycles from input transfer to out_valid_o with no backpressure. Throughput is 1 per cycle.
  - S1: capture operand, sign, rnd_mode; compute magnitude (negate if signed_i && MSB). Most-negative value gives magnitude 2^(INT_W-1), held as INT_W-bit unsigned.
  - S2: leading-one detect; normalise shift; compute exponent = pos + BIAS; derive guard bit and sticky (OR of remaining bits).
  - S3: round, handle mantissa carry (mantissa wraps to 0, exponent +1), detect overflow, pack. S3 drives the outputs directly.
- Flow control:
  - Each stage advances when its downstream register is empty or is being emptied in the same cycle.
  - in_ready_o = !v1 || S1 advances. in_ready_o is combinationally dependent on out_ready_i.
  - All 3 stages may be full at once; order is preserved and nothing is dropped or duplicated.
- Zero input: fp_o = all zeros (+0, including signed mode), inexact_o = 0.
- Rounding with increment = inc, guard = G, sticky = S, lsb = L:
  - RNE: inc = G && (S || L).
  - RTZ: inc = 0.
  - RDN: inc = sign && (G || S).
  - RUP: inc = !sign && (G || S).
- inexact_o = G || S. If MAN_W+1 >= significant bits, G = S = 0.
- Overflow: raised when the biased exponent after rounding >= 2^EXP_W-1. Then overflow_o = 1 and inexact_o = 1, with result by mode:
  - RNE: ±inf.
  - RTZ: ±max finite.
  - RDN: +max finite for positive, -inf for negative.
  - RUP: +inf for positive, -max finite for negative.
- No NaN or subnormal output is possible for integer inputs.

Test Plan:
- Defaults, RNE, signed: 1 -> 0x3F80; -1 -> 0xBF80; 0 -> 0x0000. All with inexact_o = 0 and latency exactly 3 cycles.
- int_i = 0x80000000: signed -> 0xCF00, unsigned -> 0x4F00. Both exact.
- Ties, unsigned:
  - 257 RNE -> 0x4380, inexact 1.
  - 257 RUP -> 0x4381.
  - 259 RNE -> 0x4382.
  - 257 RTZ -> 0x4380.
- Mantissa carry: 0xFFFFFFFF unsigned RNE -> 0x4F80, inexact 1. Same input RTZ -> 0x4F7F.
- EXP_W=5, MAN_W=10, unsigned 70000:
  - RNE -> 0x7C00, overflow 1, inexact 1.
  - RTZ -> 0x7BFF.
  - Signed -70000 RUP -> 0xFBFF.
- Backpressure:
  - Hold out_ready_i = 0 and stream 5 back-to-back operands. Exactly 3 are accepted, then in_ready_o = 0 and fp_o is held stable.
  - Release out_ready_i: all 5 results emerge in order, one per cycle, with no loss.
  - Assert rst_ni low mid-stream: out_valid_o drops immediately and no stale result appears after reset.
